hs_stream_buffer: RTL and testbench
===================================

// Module: hs_stream_buffer
// PURPOSE
//  Parametrised valid/ready stream buffer between one producer and one consumer.
//  Generalises the single-bit sender/receiver handshake to WIDTH-bit data and DEPTH-entry storage.
//  Adds occupancy reporting and an almost-full flag.
//  Sits on any point-to-point stream where back-pressure must be absorbed without losing data.
// PARAMETERS
//  WIDTH      8   data bits per beat (>=1)
//  DEPTH      4   storage entries (>=2; need not be a power of two)
//  AF_THRESH  3   almost_full asserts when level >= AF_THRESH (1..DEPTH)
// PORTS
//  clk          in   1              single clock; all logic on posedge
//  rst          in   1              synchronous, active-low reset
//  s_data       in   WIDTH          upstream data
//  s_valid      in   1              upstream beat present
//  s_ready      out  1              buffer can accept a beat this cycle
//  m_data       out  WIDTH          downstream data (head entry)
//  m_valid      out  1              head entry present
//  m_ready      in   1              downstream accepts head this cycle
//  level        out  $clog2(DEPTH+1) entries currently stored
//  almost_full  out  1              level >= AF_THRESH
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr/rd pointers, level = 0; s_ready, m_valid, almost_full = 0.
//    Storage contents are not reset. m_data is don't-care while m_valid==0.
//  - First cycle after rst returns high: s_ready = 1.
//  - Reset asserted mid-stream discards every stored beat; no beat is transferred in a reset cycle.
//  - push = s_valid & s_ready; pop = m_valid & m_ready. A transfer happens only on a cycle
//    where both signals are high at the posedge.
//  - Producer rule: once s_valid is high it stays high, with s_data stable, until accepted.
//    Consumer-side mirror: m_valid/m_data hold until popped.
//  - All outputs are registers or decode of registers. s_ready must NOT depend combinationally
//    on m_ready, and m_valid must NOT depend on s_valid.
//  - Latency: a beat pushed at edge N into an empty buffer shows m_valid=1 with that data after edge N.
//    Order is strict FIFO.
//  - Next state per edge:
//      push only -> level+1
//      pop only  -> level-1
//      both      -> level unchanged (read and write both advance)
//      neither   -> hold
//  - s_ready_next = (level_next < DEPTH); m_valid_next = (level_next != 0);
//    almost_full_next = (level_next >= AF_THRESH).
//  - Full (level==DEPTH): s_ready=0. A simultaneous pop frees the slot; s_ready returns 1 the next cycle.
//    There is no same-cycle pass-through when full.
//  - Empty (level==0): m_valid=0. A push never bypasses to m_data in the same cycle.
//  - Pointers wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
//    Level is kept as an explicit counter, not derived from pointer difference.
//  - Throughput: one beat per cycle sustained whenever 0<level<DEPTH and both sides are active.
//  - Illegal parameter combinations (DEPTH<2, AF_THRESH outside 1..DEPTH) stop elaboration.
// STRUCTURE
//  - Shared package hs_pkg:
//      clog2-based width helper for level/pointer widths
//      beat typedef generated from WIDTH by the user of the package
//  - Sub-module hs_wrap_ctr: pointer counter with enable, synchronous active-low clear,
//    and wrap at DEPTH-1. Instantiated twice, once for wr and once for rd.
//  - Top-level holds the storage array, the level counter and the registered flag logic.
// TESTING
//  1. Reset then idle, checked on the first cycle after rst high:
//     s_ready=1, m_valid=0, level=0, almost_full=0.
//  2. DEPTH=4, AF_THRESH=3, m_ready=0; push 0x11,0x22,0x33,0x44 on consecutive cycles.
//     Response: level 1..4; almost_full from level 3; s_ready=0 after the 4th push.
//     A 5th valid beat 0x55 is held, not accepted.
//  3. From full, raise m_ready for 4 cycles.
//     Response: m_data 0x11,0x22,0x33,0x44 in order; s_ready back to 1 one cycle after the first pop.
//     0x55 is then accepted.
//  4. Continuous push and pop at level 2.
//     Response: level stays 2 and one beat moves per cycle for 20 cycles.
//     Pointers wrap correctly with DEPTH=5 (non-power-of-two).
//  5. Random s_valid/m_ready at 50% each for 10k beats with an incrementing pattern.
//     Response: output sequence matches input exactly, no loss or duplication.
//     Assertions hold: m_data stable while m_valid & !m_ready, and level <= DEPTH.
//  6. Pull rst low at level 3 for one cycle.
//     Response: level=0, m_valid=0 next cycle. Stale data never re-emerges after further pushes.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared width helpers for the valid/ready stream buffer
package hs_pkg;
  function automatic int ptr_w(int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
  function automatic int lvl_w(int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hs_wrap_ctr.sv
// hs_wrap_ctr: storage pointer that advances on en and wraps from DEPTH-1 to 0
module hs_wrap_ctr
  import hs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [ptr_w(DEPTH)-1:0] q
);
  localparam int PW = ptr_w(DEPTH);
  // clear on reset, otherwise step with explicit wrap so non-power-of-two depths work
  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else if (en) q <= (q == PW'(DEPTH - 1)) ? '0 : q + 1'b1;
  end
endmodule

// File: rtl/hs_stream_buffer.sv
// hs_stream_buffer: DEPTH-entry valid/ready FIFO with registered flags and occupancy
module hs_stream_buffer
  import hs_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    almost_full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  typedef logic [WIDTH-1:0] beat_t;
  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
    $error("hs_stream_buffer: illegal DEPTH/AF_THRESH");
  end
  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;
  assign push   = s_valid & s_ready;
  assign pop    = m_valid & m_ready;
  assign m_data = mem[rd_ptr];
  hs_wrap_ctr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .rst(rst), .en(push), .q(wr_ptr));
  hs_wrap_ctr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .rst(rst), .en(pop), .q(rd_ptr));
  // occupancy moves only when exactly one side transfers
  always_comb begin
    level_next = (push && !pop) ? level + 1'b1 : (pop && !push) ? level - 1'b1 : level;
  end
  // level and flags are registered from the next level so no output sees the opposite side combinationally
  always_ff @(posedge clk) begin
    if (!rst) begin
      level       <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      s_ready     <= level_next < LW'(DEPTH);
      m_valid     <= level_next != '0;
      almost_full <= level_next >= LW'(AF_THRESH);
    end
  end
  // storage is written only on an accepted beat outside reset; contents are never cleared
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= s_data;
  end
endmodule

// File: tb/tb_hs_stream_buffer.sv
// tb_hs_stream_buffer: directed and randomised checks of hs_stream_buffer at DEPTH 4 and 5
module tb_hs_stream_buffer;
  logic       clk = 1'b0;
  logic       a_rst = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b0;
  logic [7:0] a_s_data = '0;
  logic       a_s_ready, a_m_valid, a_af;
  logic [7:0] a_m_data;
  logic [2:0] a_level;
  logic       b_rst = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
  logic [7:0] b_s_data = '0;
  logic       b_s_ready, b_m_valid, b_af;
  logic [7:0] b_m_data;
  logic [2:0] b_level;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hs_stream_buffer #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3)) u_d4 (
    .clk(clk), .rst(a_rst), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .level(a_level), .almost_full(a_af)
  );
  hs_stream_buffer #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3)) u_d5 (
    .clk(clk), .rst(b_rst), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .level(b_level), .almost_full(b_af)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wr, rd, cyc;
    logic hold, prev_stall;
    logic [7:0] prev_data;
    step();
    step();
    chk("rst_s_ready", a_s_ready, 0);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_level", a_level, 0);
    chk("rst_af", a_af, 0);
    a_rst = 1'b1;
    b_rst = 1'b1;
    step();
    chk("idle_s_ready", a_s_ready, 1);
    chk("idle_m_valid", a_m_valid, 0);
    chk("idle_level", a_level, 0);
    chk("idle_af", a_af, 0);
    a_s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_s_data = 8'(8'h11 * i);
      step();
      chk("fill_level", a_level, i);
      chk("fill_af", a_af, int'(i >= 3));
      chk("fill_s_ready", a_s_ready, int'(i < 4));
      chk("fill_head", a_m_data, 8'h11);
    end
    a_s_data = 8'h55;
    step();
    chk("full_hold_level", a_level, 4);
    chk("full_hold_s_ready", a_s_ready, 0);
    a_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", a_m_data, 8'h11 * (i + 1));
      step();
      if (i == 0) chk("s_ready_back", a_s_ready, 1);
      if (i == 1) begin
        chk("pushpop_level", a_level, 3);
        a_s_valid = 1'b0;
      end
    end
    chk("late_level", a_level, 1);
    chk("late_data", a_m_data, 8'h55);
    step();
    a_m_ready = 1'b0;
    chk("empty_m_valid", a_m_valid, 0);
    chk("empty_level", a_level, 0);
    a_s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_s_data = 8'(8'hA0 + i);
      step();
    end
    a_s_valid = 1'b0;
    chk("pre_rst_level", a_level, 3);
    a_rst = 1'b0;
    step();
    a_rst = 1'b1;
    chk("mid_rst_level", a_level, 0);
    chk("mid_rst_m_valid", a_m_valid, 0);
    step();
    a_s_valid = 1'b1;
    a_s_data = 8'hB1;
    step();
    a_s_valid = 1'b0;
    chk("post_rst_level", a_level, 1);
    chk("post_rst_data", a_m_data, 8'hB1);
    b_s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_s_data = 8'(i);
      step();
    end
    chk("d5_level2", b_level, 2);
    b_m_ready = 1'b1;
    wr = 2;
    rd = 0;
    for (int i = 0; i < 20; i++) begin
      chk("stream_data", b_m_data, rd);
      b_s_data = 8'(wr);
      step();
      wr++;
      rd++;
      chk("stream_level", b_level, 2);
    end
    b_s_valid = 1'b0;
    step();
    step();
    chk("d5_drained", b_m_valid, 0);
    wr = 0;
    rd = 0;
    cyc = 0;
    hold = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (rd < 10000 && cyc < 60000) begin
      if (prev_stall) chk("rnd_stable", b_m_data, prev_data);
      chk("rnd_level_max", int'(b_level <= 3'd5), 1);
      if (!hold) begin
        b_s_valid = (wr < 10000) && ($urandom_range(1) == 1);
        b_s_data = 8'(wr);
      end
      b_m_ready = ($urandom_range(1) == 1);
      if (b_s_valid && b_s_ready) begin
        wr++;
        hold = 1'b0;
      end else hold = b_s_valid;
      if (b_m_valid && b_m_ready) begin
        chk("rnd_data", b_m_data, rd & 255);
        rd++;
      end
      prev_stall = b_m_valid && !b_m_ready;
      prev_data = b_m_data;
      step();
      cyc++;
    end
    chk("rnd_count", rd, 10000);
    b_s_valid = 1'b0;
    b_m_ready = 1'b0;
    step();
    chk("rnd_empty", b_level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
